// File: rtl/microcode_sequencer_if.sv
// Bundle between the microcode sequencer and whatever drives it: opcode/restart
// in, control word and status out. The sequencer connects through the slave modport.
interface microcode_sequencer_if #(
  parameter int CTRL_WIDTH = 15
);
  logic [5:0]          opcode;
  logic                restart;
  logic [CTRL_WIDTH:0] ctrl;
  logic [3:0]          upc;
  logic                done;
  logic                halted;
  logic [5:0]          bad_opcode;
  logic [31:0]         instr_count;

  modport master (
    output opcode, restart,
    input  ctrl, upc, done, halted, bad_opcode, instr_count
  );

  modport slave (
    input  opcode, restart,
    output ctrl, upc, done, halted, bad_opcode, instr_count
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcoded control unit for the multicycle MIPS datapath: micro-PC, control ROM,
// two opcode dispatch tables, and retire/halt bookkeeping.
module microcode_sequencer #(
  parameter int         CTRL_WIDTH = 15,
  parameter logic [5:0] OP_LW      = 6'h00,
  parameter logic [5:0] OP_SW      = 6'h01,
  parameter logic [5:0] OP_RTYPE   = 6'h02,
  parameter logic [5:0] OP_J       = 6'h03,
  parameter logic [5:0] OP_BEQ     = 6'h04
) (
  input logic                   clk,
  input logic                   rst,
  microcode_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CTRL_WIDTH:0] ctrl_next;
  logic                terminal;
  logic                halt_entry;

  logic [CTRL_WIDTH:0] ctrl_q;
  logic                done_q;
  logic                halted_q;
  logic [5:0]          bad_opcode_q;
  logic [31:0]         instr_count_q;

  function automatic state_t dispatch1(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: dispatch1 = S_MEMADR;
      OP_RTYPE:     dispatch1 = S_EXEC;
      OP_BEQ:       dispatch1 = S_BRANCH;
      OP_J:         dispatch1 = S_JUMP;
      default:      dispatch1 = S_HALT;
    endcase
  endfunction

  function automatic state_t dispatch2(input logic [5:0] op);
    case (op)
      OP_LW:   dispatch2 = S_MEMRD;
      OP_SW:   dispatch2 = S_MEMWR;
      default: dispatch2 = S_HALT;
    endcase
  endfunction

  function automatic logic [15:0] rom(input state_t s);
    case (s)
      S_FETCH:  rom = 16'h084A;
      S_DECODE: rom = 16'h1800;
      S_MEMADR: rom = 16'h3000;
      S_MEMRD:  rom = 16'h000C;
      S_MEMWB:  rom = 16'h4020;
      S_MEMWR:  rom = 16'h0014;
      S_EXEC:   rom = 16'h2400;
      S_RWB:    rom = 16'hC000;
      S_BRANCH: rom = 16'h2281;
      S_JUMP:   rom = 16'h0102;
      default:  rom = 16'h0000;
    endcase
  endfunction

  // State register: the micro-PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state: restart overrides every state, including IDLE and HALT.
  always_comb begin
    state_next = S_HALT;
    if (bus.restart) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_FETCH:  state_next = S_DECODE;
        S_DECODE: state_next = dispatch1(bus.opcode);
        S_MEMADR: state_next = dispatch2(bus.opcode);
        S_MEMRD:  state_next = S_MEMWB;
        S_EXEC:   state_next = S_RWB;
        S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
        S_HALT:   state_next = S_HALT;
        default:  state_next = S_HALT;
      endcase
    end
  end

  // Outputs: ctrl is loaded from ROM[state_next] so the flop always equals ROM[upc].
  always_comb begin
    ctrl_next  = (CTRL_WIDTH+1)'(rom(state_next));
    terminal   = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_RWB) ||
                 (state == S_BRANCH) || (state == S_JUMP);
    halt_entry = (state == S_DECODE) && (state_next == S_HALT);
  end

  // Retirement is credited even when restart coincides with a terminal state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q        <= '0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      bad_opcode_q  <= 6'h00;
      instr_count_q <= 32'h0;
    end else begin
      ctrl_q   <= ctrl_next;
      done_q   <= terminal;
      halted_q <= (state_next == S_HALT);
      if (terminal)   instr_count_q <= instr_count_q + 32'd1;
      if (halt_entry) bad_opcode_q  <= bus.opcode;
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.upc         = state;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;
  assign bus.bad_opcode  = bad_opcode_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios with literal expectations, then
// random opcode/restart traffic, all compared every cycle to an instruction-level model.
module tb_microcode_sequencer;

  localparam logic [5:0] OP_LW    = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h01;
  localparam logic [5:0] OP_RTYPE = 6'h02;
  localparam logic [5:0] OP_J     = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic rst;

  microcode_sequencer_if #(.CTRL_WIDTH(15)) bus ();

  microcode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Model: an instruction is a list of {upc, ctrl} words; FETCH and DECODE are
  // common, the remainder is chosen from the opcode when DECODE is left.
  logic [19:0] m_cur;
  logic [19:0] m_pend[$];
  int          m_mode;
  bit          m_decoded;
  logic        m_done;
  logic        m_halted;
  logic [5:0]  m_bad;
  logic [31:0] m_count;

  task automatic model_reset();
    m_cur = 20'h0; m_pend.delete(); m_mode = M_IDLE; m_decoded = 0;
    m_done = 0; m_halted = 0; m_bad = 6'h00; m_count = 32'h0;
  endtask

  task automatic start_instr();
    m_mode = M_RUN;
    m_cur = {4'd1, 16'h084A};
    m_pend.delete();
    m_pend.push_back({4'd2, 16'h1800});
    m_decoded = 0;
  endtask

  task automatic model_step(input logic r, input logic [5:0] op);
    bit term;
    term = (m_mode == M_RUN) && m_decoded && (m_pend.size() == 0);
    m_done = term;
    if (term) m_count = m_count + 32'd1;
    if (r) begin
      start_instr();
      m_halted = 0;
    end else if (m_mode == M_RUN) begin
      if (term) start_instr();
      else if (m_pend.size() != 0) m_cur = m_pend.pop_front();
      else begin
        case (op)
          OP_LW:    begin m_pend.push_back({4'd3, 16'h3000}); m_pend.push_back({4'd4, 16'h000C}); m_pend.push_back({4'd5, 16'h4020}); end
          OP_SW:    begin m_pend.push_back({4'd3, 16'h3000}); m_pend.push_back({4'd6, 16'h0014}); end
          OP_RTYPE: begin m_pend.push_back({4'd7, 16'h2400}); m_pend.push_back({4'd8, 16'hC000}); end
          OP_BEQ:   m_pend.push_back({4'd9, 16'h2281});
          OP_J:     m_pend.push_back({4'd10, 16'h0102});
          default:  ;
        endcase
        if (m_pend.size() != 0) begin
          m_decoded = 1;
          m_cur = m_pend.pop_front();
        end else begin
          m_mode = M_HALT; m_cur = {4'd11, 16'h0000}; m_halted = 1; m_bad = op;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("upc",         {28'h0, bus.upc},     {28'h0, m_cur[19:16]});
    check("ctrl",        {16'h0, bus.ctrl},    {16'h0, m_cur[15:0]});
    check("done",        {31'h0, bus.done},    {31'h0, m_done});
    check("halted",      {31'h0, bus.halted},  {31'h0, m_halted});
    check("bad_opcode",  {26'h0, bus.bad_opcode}, {26'h0, m_bad});
    check("instr_count", bus.instr_count,      m_count);
  endtask

  // Driver: apply inputs for the coming edge, step the model on it, compare after.
  task automatic tick(input logic r, input logic [5:0] op);
    bus.restart = r;
    bus.opcode  = op;
    @(posedge clk);
    model_step(r, op);
    #1;
    compare_all();
  endtask

  logic [5:0]  prog[5];
  int          lat_exp[5];
  int          cycles;
  int          seen_c000, seen_2281, seen_0102;
  logic [31:0] c0;
  logic [5:0]  rnd_op;
  logic        rnd_r;

  initial begin
    rst = 1'b1;
    bus.restart = 1'b0;
    bus.opcode  = OP_LW;
    model_reset();
    #12;
    check("reset_ctrl",  {16'h0, bus.ctrl}, 32'h0);
    check("reset_upc",   {28'h0, bus.upc},  32'h0);
    check("reset_count", bus.instr_count,   32'h0);
    compare_all();
    #1 rst = 1'b0;

    tick(0, OP_LW);
    tick(0, OP_LW);
    check("idle_hold", {28'h0, bus.upc}, 32'd0);

    // LW from restart
    tick(1, OP_LW); check("lw_fetch",  {16'h0, bus.ctrl}, 32'h084A);
    tick(0, OP_LW); check("lw_decode", {16'h0, bus.ctrl}, 32'h1800);
    tick(0, OP_LW); check("lw_memadr", {16'h0, bus.ctrl}, 32'h3000);
    tick(0, OP_LW); check("lw_memrd",  {16'h0, bus.ctrl}, 32'h000C);
    tick(0, OP_LW); check("lw_memwb",  {16'h0, bus.ctrl}, 32'h4020);
    tick(0, OP_LW); check("lw_ret_ctrl", {16'h0, bus.ctrl}, 32'h084A);
    check("lw_ret_done", {31'h0, bus.done}, 32'd1);
    check("lw_ret_count", bus.instr_count, 32'd1);

    // SW skips MEMRD
    tick(0, OP_SW); check("sw_decode", {16'h0, bus.ctrl}, 32'h1800);
    tick(0, OP_SW); check("sw_memadr", {16'h0, bus.ctrl}, 32'h3000);
    tick(0, OP_SW); check("sw_memwr",  {16'h0, bus.ctrl}, 32'h0014);
    tick(0, OP_SW); check("sw_ret_done", {31'h0, bus.done}, 32'd1);
    check("sw_ret_upc", {28'h0, bus.upc}, 32'd1);

    // Back-to-back program and retire latencies
    prog    = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J};
    lat_exp = '{5, 4, 4, 3, 3};
    seen_c000 = 0; seen_2281 = 0; seen_0102 = 0;
    c0 = m_count;
    for (int i = 0; i < 5; i++) begin
      cycles = 0;
      do begin
        tick(0, prog[i]);
        cycles++;
        if (bus.ctrl == 16'hC000) seen_c000++;
        if (bus.ctrl == 16'h2281) seen_2281++;
        if (bus.ctrl == 16'h0102) seen_0102++;
      end while (!bus.done && cycles < 12);
      check($sformatf("latency_%0d", i), cycles, lat_exp[i]);
    end
    check("prog_count", bus.instr_count - c0, 32'd5);
    check("seen_c000", seen_c000, 32'd1);
    check("seen_2281", seen_2281, 32'd1);
    check("seen_0102", seen_0102, 32'd1);

    // Illegal opcode parks in HALT
    c0 = m_count;
    tick(0, 6'h3F);
    tick(0, 6'h3F);
    check("ill_upc",    {28'h0, bus.upc},        32'd11);
    check("ill_ctrl",   {16'h0, bus.ctrl},       32'h0);
    check("ill_halted", {31'h0, bus.halted},     32'd1);
    check("ill_bad",    {26'h0, bus.bad_opcode}, 32'h3F);
    check("ill_count",  bus.instr_count,         c0);
    tick(0, OP_LW);
    tick(0, OP_LW);
    check("ill_stay", {28'h0, bus.upc}, 32'd11);
    tick(1, OP_LW);
    check("ill_rs_upc",    {28'h0, bus.upc},        32'd1);
    check("ill_rs_halted", {31'h0, bus.halted},     32'd0);
    check("ill_rs_bad",    {26'h0, bus.bad_opcode}, 32'h3F);

    // Restart in MEMRD aborts without retiring
    tick(0, OP_LW); tick(0, OP_LW); tick(0, OP_LW);
    check("memrd_ctrl", {16'h0, bus.ctrl}, 32'h000C);
    c0 = m_count;
    tick(1, OP_LW);
    check("abort_upc",   {28'h0, bus.upc},  32'd1);
    check("abort_done",  {31'h0, bus.done}, 32'd0);
    check("abort_count", bus.instr_count,   c0);

    // Restart in RWB still retires
    tick(0, OP_RTYPE); tick(0, OP_RTYPE); tick(0, OP_RTYPE);
    check("rwb_ctrl", {16'h0, bus.ctrl}, 32'hC000);
    tick(1, OP_RTYPE);
    check("rwb_rs_done",  {31'h0, bus.done}, 32'd1);
    check("rwb_rs_count", bus.instr_count,   c0 + 32'd1);

    // Asynchronous reset mid-EXEC
    tick(0, OP_RTYPE); tick(0, OP_RTYPE);
    check("exec_ctrl", {16'h0, bus.ctrl}, 32'h2400);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("arst_ctrl",  {16'h0, bus.ctrl}, 32'h0);
    check("arst_upc",   {28'h0, bus.upc},  32'h0);
    check("arst_count", bus.instr_count,   32'h0);
    #1 rst = 1'b0;
    tick(0, OP_LW); tick(0, OP_LW); tick(0, OP_LW);
    check("arst_idle", {28'h0, bus.upc}, 32'd0);

    // Random traffic; opcode changes only while no dispatch is pending
    rnd_op = OP_LW;
    for (int n = 0; n < 800; n++) begin
      rnd_r = ($urandom_range(0, 99) < 5) || (m_mode != M_RUN && $urandom_range(0, 3) == 0);
      if (m_cur[19:16] == 4'd0 || m_cur[19:16] == 4'd1 || m_cur[19:16] == 4'd11) begin
        if ($urandom_range(0, 19) == 0) rnd_op = 6'($urandom_range(5, 63));
        else rnd_op = 6'($urandom_range(0, 4));
      end
      tick(rnd_r, rnd_op);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
